// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : vga_pkg                                                      |
// | Description : Shared VGA timing constants (1024x768@60, 65 MHz pixel clk), |
// |               counter type and a small conversion helper. Used by the      |
// |               timing generator and by downstream draw stages.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vga_pkg;

   // Width of the pixel/line counters on every timing interface.
   localparam int CNT_W = 11;

   // Horizontal timing, in pixels.
   localparam int H_VISIBLE_DEF = 1024;
   localparam int H_FRONT_DEF   = 24;
   localparam int H_SYNC_DEF    = 136;
   localparam int H_BACK_DEF    = 160;
   localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   // Vertical timing, in lines.
   localparam int V_VISIBLE_DEF = 768;
   localparam int V_FRONT_DEF   = 3;
   localparam int V_SYNC_DEF    = 6;
   localparam int V_BACK_DEF    = 29;
   localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef logic [CNT_W-1:0] cnt_t;

   // Narrow an integer timing value to the counter width.
   function automatic cnt_t to_cnt(input int value);
      return cnt_t'(value);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : Free-running VGA raster timing generator. Two counters       |
// |               (pixel column, line) plus one registered decode stage for    |
// |               sync, blanking and frame-start flags. Every output comes     |
// |               straight from a flop.                                        |
// | Ports       : clk          in   pixel clock                                |
// |               reset        in   synchronous, active-high                   |
// |               hcount_out   out  [10:0] pixel column, 0..H_TOTAL-1          |
// |               vcount_out   out  [10:0] line, 0..V_TOTAL-1                  |
// |               hsync_out    out  horizontal sync, active-high               |
// |               vsync_out    out  vertical sync, active-high                 |
// |               hblnk_out    out  high outside horizontal active region      |
// |               vblnk_out    out  high outside vertical active region        |
// |               frame_start  out  one-cycle pulse at pixel (0,0)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic             frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Decode boundaries narrowed to counter width so all compares are 11-bit.
   localparam cnt_t C_H_LAST     = to_cnt(H_TOTAL - 1);
   localparam cnt_t C_V_LAST     = to_cnt(V_TOTAL - 1);
   localparam cnt_t C_H_BLNK_BEG = to_cnt(H_VISIBLE);
   localparam cnt_t C_V_BLNK_BEG = to_cnt(V_VISIBLE);
   localparam cnt_t C_H_SYNC_BEG = to_cnt(H_VISIBLE + H_FRONT);
   localparam cnt_t C_H_SYNC_END = to_cnt(H_VISIBLE + H_FRONT + H_SYNC);
   localparam cnt_t C_V_SYNC_BEG = to_cnt(V_VISIBLE + V_FRONT);
   localparam cnt_t C_V_SYNC_END = to_cnt(V_VISIBLE + V_FRONT + V_SYNC);

   cnt_t hcount_q, hcount_d;
   cnt_t vcount_q, vcount_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic hblnk_q, hblnk_d;
   logic vblnk_q, vblnk_d;
   logic frame_start_q, frame_start_d;

   logic w_h_wrap;
   logic w_v_wrap;

   always_comb begin
      // '>=' rather than '==' so an out-of-range count can never persist.
      w_h_wrap = (hcount_q >= C_H_LAST);
      w_v_wrap = (vcount_q >= C_V_LAST);

      hcount_d = w_h_wrap ? '0 : hcount_q + 1'b1;

      vcount_d = vcount_q;
      if (w_h_wrap) begin
         vcount_d = w_v_wrap ? '0 : vcount_q + 1'b1;
      end

      // Flags decode the next-state counts so that, once registered, they
      // line up with the counter outputs in the same cycle.
      hblnk_d       = (hcount_d >= C_H_BLNK_BEG);
      vblnk_d       = (vcount_d >= C_V_BLNK_BEG);
      hsync_d       = (hcount_d >= C_H_SYNC_BEG) && (hcount_d < C_H_SYNC_END);
      vsync_d       = (vcount_d >= C_V_SYNC_BEG) && (vcount_d < C_V_SYNC_END);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount_out  = hcount_q;
   assign vcount_out  = vcount_q;
   assign hsync_out   = hsync_q;
   assign vsync_out   = vsync_q;
   assign hblnk_out   = hblnk_q;
   assign vblnk_out   = vblnk_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Self-checking bench. A default-mode instance and a tiny-mode |
// |               instance (24x7 raster) run side by side; an arithmetic model |
// |               derived from edges-since-reset is compared every cycle, and  |
// |               directed literal checks pin key raster positions.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        rst_d = 1'b1;
   logic        rst_s = 1'b1;

   logic [10:0] d_h, d_v, s_h, s_v;
   logic        d_hs, d_vs, d_hb, d_vb, d_fs;
   logic        s_hs, s_vs, s_hb, s_vb, s_fs;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen dut (
      .clk(clk), .reset(rst_d),
      .hcount_out(d_h), .vcount_out(d_v),
      .hsync_out(d_hs), .vsync_out(d_vs),
      .hblnk_out(d_hb), .vblnk_out(d_vb),
      .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4),  .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_s (
      .clk(clk), .reset(rst_s),
      .hcount_out(s_h), .vcount_out(s_v),
      .hsync_out(s_hs), .vsync_out(s_vs),
      .hblnk_out(s_hb), .vblnk_out(s_vb),
      .frame_start(s_fs)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Position is purely a function of edges elapsed since reset released.
   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic hs, vs, hb, vb, fs;
   } exp_t;

   function automatic exp_t model(input int n, input bit held,
                                  input int hv, input int hf, input int hsw, input int hbp,
                                  input int vv, input int vf, input int vsw, input int vbp);
      exp_t e;
      int ht = hv + hf + hsw + hbp;
      int vt = vv + vf + vsw + vbp;
      int h  = n % ht;
      int v  = (n / ht) % vt;
      e.h  = 11'(h);
      e.v  = 11'(v);
      e.hb = !held && (h >= hv);
      e.vb = !held && (v >= vv);
      e.hs = !held && (h >= hv + hf) && (h < hv + hf + hsw);
      e.vs = !held && (v >= vv + vf) && (v < vv + vf + vsw);
      e.fs = !held && (h == 0) && (v == 0);
      return e;
   endfunction

   int n_d = 0, n_s = 0;
   bit held_d = 1'b1, held_s = 1'b1;

   always @(posedge clk) begin
      if (rst_d) begin n_d <= 0; held_d <= 1'b1; end
      else       begin n_d <= n_d + 1; held_d <= 1'b0; end
      if (rst_s) begin n_s <= 0; held_s <= 1'b1; end
      else       begin n_s <= n_s + 1; held_s <= 1'b0; end
   end

   // Single compare process: every cycle, both instances, every output.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t ed, es;
         ed = model(n_d, held_d, 1024, 24, 136, 160, 768, 3, 6, 29);
         es = model(n_s, held_s, 16, 2, 3, 3, 4, 1, 1, 1);
         chk("d.hcount", 32'(d_h), 32'(ed.h));
         chk("d.vcount", 32'(d_v), 32'(ed.v));
         chk("d.hsync",  32'(d_hs), 32'(ed.hs));
         chk("d.vsync",  32'(d_vs), 32'(ed.vs));
         chk("d.hblnk",  32'(d_hb), 32'(ed.hb));
         chk("d.vblnk",  32'(d_vb), 32'(ed.vb));
         chk("d.fstart", 32'(d_fs), 32'(ed.fs));
         chk("s.hcount", 32'(s_h), 32'(es.h));
         chk("s.vcount", 32'(s_v), 32'(es.v));
         chk("s.hsync",  32'(s_hs), 32'(es.hs));
         chk("s.vsync",  32'(s_vs), 32'(es.vs));
         chk("s.hblnk",  32'(s_hb), 32'(es.hb));
         chk("s.vblnk",  32'(s_vb), 32'(es.vb));
         chk("s.fstart", 32'(s_fs), 32'(es.fs));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      int e, run, k, pulses;
      bit found;

      step(3);
      chk_en = 1'b1;
      chk("lit.rst.d.h",  32'(d_h), 0);
      chk("lit.rst.d.v",  32'(d_v), 0);
      chk("lit.rst.d.fs", 32'(d_fs), 0);
      chk("lit.rst.s.hb", 32'(s_hb), 0);

      rst_d = 1'b0;
      rst_s = 1'b0;
      e = 0;

      step(1); e = 1;
      chk("lit.first.d.h", 32'(d_h), 1);
      chk("lit.first.d.v", 32'(d_v), 0);
      chk("lit.first.s.h", 32'(s_h), 1);

      step(1022); e = 1023;
      chk("lit.d.h1023",    32'(d_h), 1023);
      chk("lit.d.hb@1023",  32'(d_hb), 0);
      step(1); e = 1024;
      chk("lit.d.hb@1024",  32'(d_hb), 1);
      chk("lit.s.hb@16",    32'(s_hb), 1);   // 1024 mod 24 = 16
      step(23); e = 1047;
      chk("lit.d.hs@1047",  32'(d_hs), 0);
      step(1); e = 1048;
      chk("lit.d.hs@1048",  32'(d_hs), 1);

      run = 0;
      for (int i = 0; i < 200 && d_hs; i++) begin
         run++;
         step(1);
      end
      e = e + run;
      chk("lit.d.hs_width", run, 136);
      chk("lit.d.hs@end",   32'(d_h), 1184);

      if (e < 1343) step(1343 - e);
      e = 1343;
      chk("lit.d.h1343",    32'(d_h), 1343);
      step(1); e = 1344;
      chk("lit.d.wrap.h",   32'(d_h), 0);
      chk("lit.d.wrap.v",   32'(d_v), 1);
      chk("lit.d.wrap.hb",  32'(d_hb), 0);
      chk("lit.d.wrap.fs",  32'(d_fs), 0);
      chk("lit.s.fs@1344",  32'(s_fs), 1);   // 1344 = 8 * 168

      // Three small frames: pulses at edges 1512, 1680, 1848.
      pulses = 0;
      for (int i = 0; i < 504; i++) begin
         step(1);
         if (s_fs) pulses++;
      end
      chk("lit.s.fs_count", pulses, 3);

      // Reset the small instance while inside both hsync and vsync.
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (s_h == 11'd19 && s_v == 11'd5) found = 1'b1;
         else step(1);
      end
      chk("wait.s.in_sync", 32'(found), 1);
      chk("lit.s.vs_in_sync", 32'(s_vs), 1);
      rst_s = 1'b1;
      step(1);
      chk("lit.srst.h",  32'(s_h), 0);
      chk("lit.srst.hs", 32'(s_hs), 0);
      chk("lit.srst.vs", 32'(s_vs), 0);
      chk("lit.srst.vb", 32'(s_vb), 0);
      chk("lit.srst.fs", 32'(s_fs), 0);
      rst_s = 1'b0;
      step(1);
      chk("lit.srel.h",  32'(s_h), 1);
      chk("lit.srel.v",  32'(s_v), 0);
      k = 1;
      while (!s_fs && k < 400) begin
         step(1);
         k++;
      end
      chk("lit.s.first_fs_edges", k, 168);

      // Reset the default instance mid-line, inside hsync.
      found = 1'b0;
      for (int i = 0; i < 1500 && !found; i++) begin
         if (d_h == 11'd1100) found = 1'b1;
         else step(1);
      end
      chk("wait.d.h1100", 32'(found), 1);
      rst_d = 1'b1;
      step(1);
      chk("lit.drst.h",  32'(d_h), 0);
      chk("lit.drst.hs", 32'(d_hs), 0);
      chk("lit.drst.hb", 32'(d_hb), 0);
      rst_d = 1'b0;
      step(1);
      chk("lit.drel.h",  32'(d_h), 1);
      step(1046);
      chk("lit.drel.hs@1047", 32'(d_hs), 0);
      step(1);
      chk("lit.drel.hs@1048", 32'(d_hs), 1);
      chk("lit.drel.v",       32'(d_v), 0);

      step(400);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 1024, active pixels per line.
REQ-002 Parameter H_FRONT, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 160, horizontal back porch in pixels; H_TOTAL = sum of the four = 1344.
REQ-005 Parameter V_VISIBLE, default 768, active lines per frame.
REQ-006 Parameter V_FRONT, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 29, vertical back porch in lines; V_TOTAL = 806.
REQ-009 clk  input  1  pixel clock (65 MHz for the default mode).
REQ-010 reset  input  1  reset, synchronous, active-high.
REQ-011 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-012 vcount_out  output  11  current line, 0..V_TOTAL-1.
REQ-013 hsync_out  output  1  horizontal sync, active-high.
REQ-014 vsync_out  output  1  vertical sync, active-high.
REQ-015 hblnk_out  output  1  high outside the horizontal active region.
REQ-016 vblnk_out  output  1  high outside the vertical active region.
REQ-017 frame_start  output  1  one-cycle pulse marking pixel (0,0).

Function
REQ-018 All outputs SHALL be driven directly from flip-flops; no combinational path from the counters to any output.
REQ-019 hcount_out SHALL increment by 1 each clk cycle and wrap from H_TOTAL-1 to 0.
REQ-020 vcount_out SHALL increment by 1 on the cycle hcount_out wraps, and SHALL otherwise hold.
REQ-021 vcount_out SHALL wrap from V_TOTAL-1 to 0 when hcount_out also wraps.
REQ-022 hblnk_out SHALL be 1 exactly when hcount_out >= H_VISIBLE (1024..1343).
REQ-023 hsync_out SHALL be 1 exactly when H_VISIBLE+H_FRONT <= hcount_out < H_VISIBLE+H_FRONT+H_SYNC (1048..1183).
REQ-024 vblnk_out SHALL be 1 exactly when vcount_out >= V_VISIBLE (768..805).
REQ-025 vsync_out SHALL be 1 exactly when V_VISIBLE+V_FRONT <= vcount_out < V_VISIBLE+V_FRONT+V_SYNC (771..776).
REQ-026 All flags SHALL be coherent with hcount_out/vcount_out in the same cycle (decode from next-state counter values, zero relative latency).
REQ-027 frame_start SHALL be 1 exactly in cycles where hcount_out=0 and vcount_out=0, except the reset-held state (REQ-030).
REQ-028 Counter arithmetic SHALL be 11-bit unsigned; values >= H_TOTAL/V_TOTAL SHALL never appear on the outputs.
REQ-029 Sync polarity inversion for the connector is out of scope; it happens at top level.

Reset
REQ-030 While reset=1: hcount_out=0, vcount_out=0, hsync_out=0, vsync_out=0, hblnk_out=0, vblnk_out=0, frame_start=0.
REQ-031 First edge with reset=0 SHALL produce hcount_out=1, vcount_out=0; the first frame_start occurs at the first wrap to (0,0).
REQ-032 Reset asserted mid-line or mid-frame SHALL return all outputs to REQ-030 values on the next edge, with no partial sync pulse afterwards.

Structure
REQ-033 Default timing constants (1024x768@60 values) SHALL live in shared package vga_pkg, used by this block and downstream draw stages.
REQ-034 Single module, no sub-module; two counters plus one registered decode stage.

Verification
REQ-035 Release reset, run 1344 cycles -> hcount_out 1..1343 then 0; vcount_out steps 0->1 on that wrap.
REQ-036 Watch line 0 -> hblnk_out rises at hcount 1024, falls at 0; hsync_out high for exactly 136 cycles starting at hcount 1048.
REQ-037 Run one full frame (1344*806 = 1,083,264 cycles) -> vsync_out high for lines 771..776 (6*1344 cycles), vblnk_out high for lines 768..805.
REQ-038 Run two frames -> frame_start pulses exactly once per 1,083,264 cycles, each coinciding with hcount=0, vcount=0.
REQ-039 Assert reset for 1 cycle at hcount=1100, vcount=773 (inside both syncs) -> next cycle all outputs 0; then the count restarts at 1, and no sync until hcount 1048 on line 0.
REQ-040 Instantiate with H_VISIBLE=16, H_FRONT=2, H_SYNC=3, H_BACK=3, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> H_TOTAL=24, V_TOTAL=7; check the same properties exhaustively over 3 frames.
